// File: rtl/mc_ctrl_seq_pkg.sv
// Shared types for the multi-cycle control sequencer: opcodes, ALU codes,
// mux select codes, FSM state encoding and small opcode-class helpers.
package mc_pkg;

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EXE  = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_HALT = 3'd5,
    S_ERR  = 3'd6
  } state_t;

  typedef logic [5:0] opcode_t;

  localparam opcode_t OP_ADD  = 6'b000000;
  localparam opcode_t OP_SUB  = 6'b000001;
  localparam opcode_t OP_ADDI = 6'b000010;
  localparam opcode_t OP_ORI  = 6'b010000;
  localparam opcode_t OP_AND  = 6'b010001;
  localparam opcode_t OP_OR   = 6'b010010;
  localparam opcode_t OP_SLL  = 6'b011000;
  localparam opcode_t OP_SLT  = 6'b100110;
  localparam opcode_t OP_SLTI = 6'b100111;
  localparam opcode_t OP_SW   = 6'b110000;
  localparam opcode_t OP_LW   = 6'b110001;
  localparam opcode_t OP_BEQ  = 6'b110100;
  localparam opcode_t OP_J    = 6'b111000;
  localparam opcode_t OP_JR   = 6'b111001;
  localparam opcode_t OP_JAL  = 6'b111010;
  localparam opcode_t OP_HALT = 6'b111111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_SLL = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_AND = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] PC_SEQ  = 2'b00;
  localparam logic [1:0] PC_BR   = 2'b01;
  localparam logic [1:0] PC_JR   = 2'b10;
  localparam logic [1:0] PC_JUMP = 2'b11;

  localparam logic [1:0] RO_RA = 2'b00;
  localparam logic [1:0] RO_RT = 2'b01;
  localparam logic [1:0] RO_RD = 2'b10;

  localparam logic [1:0] EXT_ZERO = 2'b00;
  localparam logic [1:0] EXT_SIGN = 2'b01;

  localparam int WAIT_W = 8;

  function automatic logic is_rtype(opcode_t op);
    return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLL, OP_SLT};
  endfunction

  function automatic logic is_itype(opcode_t op);
    return op inside {OP_ADDI, OP_ORI, OP_SLTI};
  endfunction

  function automatic logic is_known(opcode_t op);
    return is_rtype(op) || is_itype(op) ||
           (op inside {OP_SW, OP_LW, OP_BEQ, OP_J, OP_JR, OP_JAL, OP_HALT});
  endfunction

  function automatic logic [2:0] alu_code(opcode_t op);
    case (op)
      OP_SUB, OP_BEQ:  return ALU_SUB;
      OP_SLL:          return ALU_SLL;
      OP_ORI, OP_OR:   return ALU_OR;
      OP_AND:          return ALU_AND;
      OP_SLT, OP_SLTI: return ALU_SLT;
      default:         return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/mc_ctrl_seq_if.sv
// Instruction/data memory req/ack handshake bundle between sequencer and memories.
interface mc_ctrl_seq_if;
  import mc_pkg::*;

  logic imem_req;
  logic imem_ack;
  logic dmem_req;
  logic dmem_ack;

  modport master (output imem_req, dmem_req, input imem_ack, dmem_ack);
  modport slave  (input imem_req, dmem_req, output imem_ack, dmem_ack);
endinterface

// File: rtl/mc_ctrl_seq_wait_timer.sv
// Watchdog for outstanding memory requests; timeout is asserted while the
// count equals MAX_WAIT.
module mc_wait_timer
  import mc_pkg::*;
#(
  parameter int MAX_WAIT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic timeout
);

  logic [WAIT_W-1:0] cnt;

  always_ff @(posedge clk)
    if (rst || clr) cnt <= '0;
    else if (en)    cnt <= cnt + WAIT_W'(1);

  assign timeout = (cnt == WAIT_W'(MAX_WAIT));

endmodule

// File: rtl/mc_ctrl_seq.sv
// Multi-cycle control FSM for the MIPS-subset core with imem/dmem req/ack handshakes.
// Define MC_CTRL_PERF_EN to build the cycle/instret performance counters.
module mc_ctrl_seq
  import mc_pkg::*;
#(
  parameter int MAX_WAIT = 15,
  parameter int OP_W     = 6,
  parameter int ALUOP_W  = 3
) (
  input  logic               CLK,
  input  logic               RST,
  mc_ctrl_seq_if.master      mem,
  input  logic [OP_W-1:0]    Opcode,
  input  logic               Zero,
  output logic               PCWre,
  output logic               IRWre,
  output logic               RegWre,
  output logic               ALUSrcB,
  output logic               ALUM2Reg,
  output logic               WrRegData,
  output logic               DataMemRW,
  output logic               InsMemRW,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic [1:0]         PCSrc,
  output logic [1:0]         RegOut,
  output logic [1:0]         ExtSel,
  output logic               halted,
  output logic               fault,
  output logic [2:0]         state,
  output logic [31:0]        cycle_cnt,
  output logic [31:0]        instret_cnt
);

  state_t     state_q, state_nxt;
  opcode_t    op;
  logic       ireq, dreq, ack_ok, tmo;
  logic [2:0] alu_c;

  assign op = opcode_t'(Opcode);

  always_ff @(posedge CLK)
    if (RST) state_q <= S_IF;
    else     state_q <= state_nxt;

  // Everything defaults low and stays low while RST is high.
  always_comb begin
    state_nxt = state_q;
    ireq      = 1'b0;
    dreq      = 1'b0;
    PCWre     = 1'b0;
    IRWre     = 1'b0;
    RegWre    = 1'b0;
    ALUSrcB   = 1'b0;
    ALUM2Reg  = 1'b0;
    WrRegData = 1'b0;
    DataMemRW = 1'b0;
    PCSrc     = PC_SEQ;
    RegOut    = RO_RA;
    ExtSel    = EXT_ZERO;
    alu_c     = ALU_ADD;
    if (!RST) begin
      case (state_q)
        S_IF:
          if (tmo) state_nxt = S_ERR;
          else begin
            ireq = 1'b1;
            if (mem.imem_ack) begin
              IRWre     = 1'b1;
              state_nxt = S_ID;
            end
          end
        S_ID:
          case (op)
            OP_J:    begin PCSrc = PC_JUMP; PCWre = 1'b1; state_nxt = S_IF; end
            OP_JAL:  begin
              RegOut = RO_RA; RegWre = 1'b1;
              PCSrc  = PC_JUMP; PCWre = 1'b1; state_nxt = S_IF;
            end
            OP_JR:   begin PCSrc = PC_JR; PCWre = 1'b1; state_nxt = S_IF; end
            OP_HALT: state_nxt = S_HALT;
            default: state_nxt = is_known(op) ? S_EXE : S_ERR;
          endcase
        S_EXE: begin
          alu_c   = alu_code(op);
          ALUSrcB = is_itype(op) || (op == OP_LW) || (op == OP_SW);
          ExtSel  = (op == OP_ORI) ? EXT_ZERO : EXT_SIGN;
          if (op == OP_BEQ) begin
            PCSrc     = Zero ? PC_BR : PC_SEQ;
            PCWre     = 1'b1;
            state_nxt = S_IF;
          end else if ((op == OP_LW) || (op == OP_SW)) state_nxt = S_MEM;
          else                                           state_nxt = S_WB;
        end
        S_MEM:
          if (tmo) state_nxt = S_ERR;
          else begin
            dreq      = 1'b1;
            DataMemRW = (op == OP_SW);
            if (mem.dmem_ack) begin
              if (op == OP_SW) begin PCWre = 1'b1; state_nxt = S_IF; end
              else state_nxt = S_WB;
            end
          end
        S_WB: begin
          RegWre    = 1'b1;
          WrRegData = 1'b1;
          ALUM2Reg  = (op == OP_LW);
          RegOut    = is_rtype(op) ? RO_RD : RO_RT;
          PCWre     = 1'b1;
          state_nxt = S_IF;
        end
        S_HALT, S_ERR: state_nxt = state_q;
        default:       state_nxt = S_ERR;
      endcase
    end
  end

  // An ack only counts when its request is being driven.
  assign ack_ok = (ireq & mem.imem_ack) | (dreq & mem.dmem_ack);

  mc_wait_timer #(.MAX_WAIT(MAX_WAIT)) u_wdt (
    .clk    (CLK),
    .rst    (RST),
    .clr    ((state_nxt != state_q) | ack_ok),
    .en     ((ireq | dreq) & ~ack_ok),
    .timeout(tmo)
  );

  assign mem.imem_req = ireq;
  assign mem.dmem_req = dreq;
  assign InsMemRW     = 1'b0;
  assign ALUOp        = ALUOP_W'(alu_c);
  assign halted       = !RST && (state_q == S_HALT);
  assign fault        = !RST && (state_q == S_ERR);
  assign state        = RST ? 3'd0 : state_q;

`ifdef MC_CTRL_PERF_EN
  always_ff @(posedge CLK)
    if (RST) begin
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else begin
      if ((state_q != S_HALT) && (state_q != S_ERR)) cycle_cnt <= cycle_cnt + 32'd1;
      if (PCWre) instret_cnt <= instret_cnt + 32'd1;
    end
`else
  assign cycle_cnt   = '0;
  assign instret_cnt = '0;
`endif

endmodule

// File: tb/tb_mc_ctrl_seq.sv
// Bench for mc_ctrl_seq: instruction table with a retire-time scoreboard,
// plus watchdog, reset, halt and performance-counter sequences.
module tb_mc_ctrl_seq;
  import mc_pkg::*;

  localparam int MW = 4;
  localparam int NV = 19;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [5:0]  Opcode = 6'd0;
  logic        Zero = 1'b0;
  logic        PCWre, IRWre, RegWre, ALUSrcB, ALUM2Reg, WrRegData, DataMemRW, InsMemRW;
  logic [2:0]  ALUOp;
  logic [1:0]  PCSrc, RegOut, ExtSel;
  logic        halted, fault;
  logic [2:0]  state;
  logic [31:0] cycle_cnt, instret_cnt;

  mc_ctrl_seq_if mif();

  mc_ctrl_seq #(.MAX_WAIT(MW), .OP_W(6), .ALUOP_W(3)) dut (
    .CLK(CLK), .RST(RST), .mem(mif), .Opcode(Opcode), .Zero(Zero),
    .PCWre(PCWre), .IRWre(IRWre), .RegWre(RegWre), .ALUSrcB(ALUSrcB),
    .ALUM2Reg(ALUM2Reg), .WrRegData(WrRegData), .DataMemRW(DataMemRW),
    .InsMemRW(InsMemRW), .ALUOp(ALUOp), .PCSrc(PCSrc), .RegOut(RegOut),
    .ExtSel(ExtSel), .halted(halted), .fault(fault), .state(state),
    .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string      name;
    logic [5:0] op;
    logic       zero;
    int         idly;
    int         ddly;
    int         cyc;
    logic [1:0] pcsrc;
    logic       regwre;
    logic [1:0] regout;
    logic       wrdata;
    logic       m2reg;
    logic       memrw;
    logic [2:0] aluop;
    logic       srcb;
    logic [1:0] ext;
  } vec_t;

  vec_t tbl [NV];
  vec_t sb [$];
  int   n_chk = 0;
  int   n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b1;
    mif.imem_ack = 1'b0;
    mif.dmem_ack = 1'b0;
    @(posedge CLK); #1;
    chk("rst.state",  32'(state), 32'd0);
    chk("rst.ireq",   32'(mif.imem_req), 32'd0);
    chk("rst.outs",   32'({PCWre, IRWre, RegWre, fault, halted}), 32'd0);
    chk("rst.cycles", cycle_cnt, 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    #1;
    chk("rel.state", 32'(state), 32'd0);
    chk("rel.ireq",  32'(mif.imem_req), 32'd1);
    chk("rel.fault", 32'(fault), 32'd0);
  endtask

  // Drives one instruction with the given wait states; compares at retire.
  task automatic run_vec(input vec_t v);
    vec_t e;
    int cyc = 0, ni = 0, nd = 0;
    bit done = 0;
    logic [1:0] pcs = 0, ro = 0, ext = 0;
    logic [2:0] alu = 0;
    logic rw = 0, wd = 0, m2 = 0, mrw = 0, srcb = 0;
    sb.push_back(v);
    Opcode = v.op;
    Zero   = v.zero;
    chk({v.name, ".start"}, 32'(state), 32'd0);
    while (!done && cyc < 40) begin
      mif.imem_ack = mif.imem_req && (ni >= v.idly);
      mif.dmem_ack = mif.dmem_req && (nd >= v.ddly);
      #1;
      cyc++;
      if (mif.imem_req) ni++;
      if (mif.dmem_req) nd++;
      if (state == 3'd2) begin alu = ALUOp; srcb = ALUSrcB; ext = ExtSel; end
      if (RegWre) begin rw = 1'b1; ro = RegOut; wd = WrRegData; m2 = ALUM2Reg; end
      if (DataMemRW) mrw = 1'b1;
      if (PCWre) begin pcs = PCSrc; done = 1; end
      @(negedge CLK);
    end
    mif.imem_ack = 1'b0;
    mif.dmem_ack = 1'b0;
    e = sb.pop_front();
    chk({e.name, ".retired"}, 32'(done),   32'd1);
    chk({e.name, ".cycles"},  32'(cyc),    32'(e.cyc));
    chk({e.name, ".pcsrc"},   32'(pcs),    32'(e.pcsrc));
    chk({e.name, ".regwre"},  32'(rw),     32'(e.regwre));
    chk({e.name, ".regout"},  32'(ro),     32'(e.regout));
    chk({e.name, ".wrdata"},  32'(wd),     32'(e.wrdata));
    chk({e.name, ".m2reg"},   32'(m2),     32'(e.m2reg));
    chk({e.name, ".memrw"},   32'(mrw),    32'(e.memrw));
    chk({e.name, ".aluop"},   32'(alu),    32'(e.aluop));
    chk({e.name, ".srcb"},    32'(srcb),   32'(e.srcb));
    chk({e.name, ".ext"},     32'(ext),    32'(e.ext));
  endtask

  task automatic run_until(input logic [2:0] tgt, output int k);
    k = 0;
    while (state != tgt && k < 10) begin
      mif.imem_ack = mif.imem_req;
      mif.dmem_ack = mif.dmem_req;
      @(negedge CLK); #1;
      k++;
    end
    mif.imem_ack = 1'b0;
    mif.dmem_ack = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int k, n;
    //                name      op       z     idly ddly cyc pcsrc   rw    regout  wd    m2    mrw   aluop   srcb  ext
    tbl[0]  = '{"add",     OP_ADD,  1'b0, 0, 0, 4,  2'b00, 1'b1, 2'b10, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 2'b01};
    tbl[1]  = '{"sub",     OP_SUB,  1'b0, 0, 0, 4,  2'b00, 1'b1, 2'b10, 1'b1, 1'b0, 1'b0, 3'b001, 1'b0, 2'b01};
    tbl[2]  = '{"addi",    OP_ADDI, 1'b0, 0, 0, 4,  2'b00, 1'b1, 2'b01, 1'b1, 1'b0, 1'b0, 3'b000, 1'b1, 2'b01};
    tbl[3]  = '{"ori",     OP_ORI,  1'b0, 0, 0, 4,  2'b00, 1'b1, 2'b01, 1'b1, 1'b0, 1'b0, 3'b011, 1'b1, 2'b00};
    tbl[4]  = '{"and",     OP_AND,  1'b0, 0, 0, 4,  2'b00, 1'b1, 2'b10, 1'b1, 1'b0, 1'b0, 3'b100, 1'b0, 2'b01};
    tbl[5]  = '{"or",      OP_OR,   1'b0, 0, 0, 4,  2'b00, 1'b1, 2'b10, 1'b1, 1'b0, 1'b0, 3'b011, 1'b0, 2'b01};
    tbl[6]  = '{"sll",     OP_SLL,  1'b0, 0, 0, 4,  2'b00, 1'b1, 2'b10, 1'b1, 1'b0, 1'b0, 3'b010, 1'b0, 2'b01};
    tbl[7]  = '{"slt",     OP_SLT,  1'b0, 0, 0, 4,  2'b00, 1'b1, 2'b10, 1'b1, 1'b0, 1'b0, 3'b111, 1'b0, 2'b01};
    tbl[8]  = '{"slti",    OP_SLTI, 1'b0, 0, 0, 4,  2'b00, 1'b1, 2'b01, 1'b1, 1'b0, 1'b0, 3'b111, 1'b1, 2'b01};
    tbl[9]  = '{"sw",      OP_SW,   1'b0, 0, 0, 4,  2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 3'b000, 1'b1, 2'b01};
    tbl[10] = '{"lw_wait", OP_LW,   1'b0, 2, 3, 10, 2'b00, 1'b1, 2'b01, 1'b1, 1'b1, 1'b0, 3'b000, 1'b1, 2'b01};
    tbl[11] = '{"lw",      OP_LW,   1'b0, 0, 0, 5,  2'b00, 1'b1, 2'b01, 1'b1, 1'b1, 1'b0, 3'b000, 1'b1, 2'b01};
    tbl[12] = '{"beq_t",   OP_BEQ,  1'b1, 0, 0, 3,  2'b01, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 3'b001, 1'b0, 2'b01};
    tbl[13] = '{"beq_nt",  OP_BEQ,  1'b0, 0, 0, 3,  2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 3'b001, 1'b0, 2'b01};
    tbl[14] = '{"j",       OP_J,    1'b0, 0, 0, 2,  2'b11, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 2'b00};
    tbl[15] = '{"jal",     OP_JAL,  1'b0, 0, 0, 2,  2'b11, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 2'b00};
    tbl[16] = '{"jr",      OP_JR,   1'b0, 0, 0, 2,  2'b10, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 2'b00};
    tbl[17] = '{"sw_wait", OP_SW,   1'b0, 1, 2, 7,  2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 3'b000, 1'b1, 2'b01};
    tbl[18] = '{"add_wait",OP_ADD,  1'b0, 3, 0, 7,  2'b00, 1'b1, 2'b10, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 2'b01};

    mif.imem_ack = 1'b0;
    mif.dmem_ack = 1'b0;

    // Performance counters: three ADDs then HALT.
    do_reset();
    for (int i = 0; i < 3; i++) run_vec(tbl[0]);
    Opcode = OP_HALT;
    run_until(3'd5, k);
    chk("halt.cycles", 32'(k), 32'd2);
    chk("halt.halted", 32'(halted), 32'd1);
    chk("halt.fault",  32'(fault), 32'd0);
`ifdef MC_CTRL_PERF_EN
    chk("perf.instret", instret_cnt, 32'd3);
    chk("perf.cycle",   cycle_cnt,   32'd14);
`else
    chk("perf.instret_off", instret_cnt, 32'd0);
    chk("perf.cycle_off",   cycle_cnt,   32'd0);
`endif
    mif.imem_ack = 1'b1;
    repeat (3) @(negedge CLK);
    #1;
    mif.imem_ack = 1'b0;
    chk("halt.stay",  32'(state), 32'd5);
    chk("halt.noreq", 32'({mif.imem_req, PCWre}), 32'd0);
`ifdef MC_CTRL_PERF_EN
    chk("perf.instret_frozen", instret_cnt, 32'd3);
    chk("perf.cycle_frozen",   cycle_cnt,   32'd14);
`endif

    // Main instruction table, back to back.
    do_reset();
    for (int i = 0; i < NV; i++) run_vec(tbl[i]);

    // Watchdog: imem never acknowledges.
    do_reset();
    Opcode = OP_ADD;
    k = 0; n = 0;
    while (state != 3'd6 && k < 20) begin
      if (mif.imem_req) n++;
      k++;
      @(negedge CLK); #1;
    end
    chk("wd.state",   32'(state), 32'd6);
    chk("wd.reqs",    32'(n), 32'(MW));
    chk("wd.fault",   32'(fault), 32'd1);
    chk("wd.req_off", 32'(mif.imem_req), 32'd0);
    mif.imem_ack = 1'b1;
    repeat (2) @(negedge CLK);
    #1;
    mif.imem_ack = 1'b0;
    chk("wd.absorb",  32'(state), 32'd6);
    chk("wd.ack_ign", 32'({mif.imem_req, IRWre}), 32'd0);
    do_reset();

    // Reset during a data handshake, then a late ack.
    Opcode = OP_LW;
    k = 0;
    while (!mif.dmem_req && k < 10) begin
      mif.imem_ack = mif.imem_req;
      @(negedge CLK); #1;
      k++;
    end
    mif.imem_ack = 1'b0;
    chk("rstmid.dreq_on", 32'(mif.dmem_req), 32'd1);
    RST = 1'b1;
    @(posedge CLK); #1;
    chk("rstmid.dreq_off", 32'(mif.dmem_req), 32'd0);
    chk("rstmid.state",    32'(state), 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    mif.dmem_ack = 1'b1;
    @(posedge CLK); #1;
    chk("rstmid.late_ack", 32'(state), 32'd0);
    chk("rstmid.dreq",     32'(mif.dmem_req), 32'd0);
    mif.dmem_ack = 1'b0;

    // Unknown opcode faults from ID.
    do_reset();
    Opcode = 6'b101010;
    run_until(3'd6, k);
    chk("unk.cycles", 32'(k), 32'd2);
    chk("unk.fault",  32'(fault), 32'd1);
    chk("unk.halted", 32'(halted), 32'd0);
    chk("unk.insrw",  32'(InsMemRW), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/mc_ctrl_seq.md
# mc_ctrl_seq

Parametrised multi-cycle control sequencer for the MIPS-subset core: it replaces the fixed-latency control unit with a state machine driving the same datapath control signals (PC write, IR write, register-file and ALU selects). It adds req/ack handshakes toward instruction and data memory, so either memory may insert wait states. A wait-state watchdog and an optional performance-counter block are included. It sits between the IR opcode field and the datapath muxes/enables of the CPU top level.

## Interface
- MAX_WAIT, 15, cycles a memory request may stay unacknowledged before a fault (1..255)
- OP_W, 6, opcode width taken from IR[31:26]
- ALUOP_W, 3, ALUOp output width
- CLK  in  1  clock, rising edge
- RST  in  1  reset, synchronous, active-high
- Opcode  in  OP_W  IR[31:26], stable from ID onward
- Zero  in  1  main-ALU zero flag, sampled in EXE
- imem_ack / dmem_ack  in  1  memory completion strobes
- imem_req / dmem_req  out  1  memory request strobes, held until ack
- PCWre, IRWre, RegWre, ALUSrcB, ALUM2Reg, WrRegData, DataMemRW  out  1  datapath enables/selects
- InsMemRW  out  1  constant 0 (instruction memory is read-only during execution)
- ALUOp  out  ALUOP_W;  PCSrc, RegOut, ExtSel  out  2 each
- halted, fault  out  1  sticky status flags
- state  out  3  current state, for debug
- cycle_cnt, instret_cnt  out  32  performance counters (see Configuration)

## Operation
- States: IF=0, ID=1, EXE=2, MEM=3, WB=4, HALT=5, ERR=6.
- IF
  - imem_req=1 until imem_ack.
  - The ack cycle pulses IRWre=1 and moves to ID.
- ID
  - J: PCSrc=11, PCWre=1, then IF.
  - JAL: RegOut=00 (r31), WrRegData=0 (PC+4), RegWre=1, PCSrc=11, PCWre=1, then IF.
  - JR: PCSrc=10, PCWre=1, then IF.
  - HALT opcode: go to HALT.
  - Unknown opcode: go to ERR, fault=1.
  - All other opcodes: go to EXE.
- EXE
  - ALUOp from the opcode. ALUSrcB=1 for I-type/LW/SW. ExtSel=00 zero-extend for ORI, otherwise 01 sign-extend.
  - BEQ: PCSrc = Zero ? 01 : 00, PCWre=1, then IF.
  - LW/SW: go to MEM.
  - All others: go to WB.
- MEM
  - dmem_req=1, and DataMemRW=1 for SW, until dmem_ack.
  - On ack, SW: PCWre=1, PCSrc=00, then IF. On ack, LW: go to WB.
- WB
  - RegWre=1, WrRegData=1, ALUM2Reg=1 for LW.
  - RegOut=10 for R-type, 01 for I-type/LW.
  - PCWre=1, PCSrc=00, then IF.
- HALT and ERR are absorbing; only RST exits them.
- Outputs are decoded combinationally from state and Opcode. Every output is 0 in any state/opcode case not listed above.
- Acks are ignored when the matching req is low.
- Watchdog (shared counter)
  - Clears on entry to IF/MEM and whenever an ack arrives.
  - Increments each cycle a req is high without ack.
  - When it reaches MAX_WAIT: go to ERR, fault=1, and the request is dropped.

## Timing
- Reset: RST high at an edge puts state=IF and clears the watchdog, halted, fault and counters. While RST is high, every output is forced to 0.
- First imem_req=1 appears in the first cycle after RST deasserts.
- Zero-wait memory (ack in the same cycle as req) gives these latencies:

  | Instruction | Cycles |
  |---|---|
  | J / JAL / JR | 2 |
  | BEQ | 3 |
  | R-type, I-type, SW | 4 |
  | LW | 5 |

- Each wait state adds exactly one cycle.
- PCWre is a single-cycle pulse, exactly once per retired instruction.
- RST asserted mid-handshake: req drops at the next edge; a late ack is ignored.
- A timeout fires on the cycle the counter equals MAX_WAIT, so at most MAX_WAIT unacknowledged request cycles occur.

## Configuration
- MC_CTRL_PERF_EN defined:
  - cycle_cnt increments every cycle that is not in reset and not in HALT/ERR.
  - instret_cnt increments on each PCWre pulse.
  - Both wrap modulo 2^32.
- MC_CTRL_PERF_EN undefined: no counter logic is built; both ports are tied to 0.

## Structure
- Package mc_pkg holds:
  - Opcodes: ADD 000000, SUB 000001, ADDI 000010, ORI 010000, AND 010001, OR 010010, SLL 011000, SLT 100110, SLTI 100111, SW 110000, LW 110001, BEQ 110100, J 111000, JR 111001, JAL 111010, HALT 111111.
  - ALUOp codes: ADD 000, SUB 001, SLL 010, OR 011, AND 100, SLT 111.
  - PCSrc codes and the state encoding.
- One sub-module, mc_wait_timer: watchdog counter with clear/enable inputs and a timeout output.

## Test plan
- ADD with zero-wait memory: state sequence IF,ID,EXE,WB; RegWre=1, RegOut=10 in WB; one PCWre pulse; 4 cycles.
- LW with imem_ack delayed 2 cycles and dmem_ack delayed 3: 10 cycles total; ALUM2Reg=1 and RegOut=01 in WB.
- BEQ with Zero=1 gives PCSrc=01 in EXE; with Zero=0 gives PCSrc=00; both take 3 cycles.
- JAL: in ID, RegOut=00, WrRegData=0, RegWre=1, PCSrc=11.
- imem_ack held low with MAX_WAIT=4: state goes to ERR after 4 request cycles, fault=1, imem_req=0 afterwards; RST recovers to IF.
- With MC_CTRL_PERF_EN: 3 ADDs then HALT give instret_cnt=3, cycle_cnt=14, and both counters then freeze.
